// File: rtl/periph_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// periph_pkg : types and board constants shared by the peripheral input path
// Revision   : 1.0
// ----------------------------------------------------------------------------
package periph_pkg;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_PEND   = 1'b1
  } debounce_state_e;

  // 10 ms at a 100 MHz system clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce : qualifies a synchronized level, with edge pulses and sticky flags
// Revision : 1.0
// ----------------------------------------------------------------------------
module debounce
  import periph_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic clr_rise,
  input  logic clr_fall,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic rise_pend,
  output logic fall_pend,
  output logic busy
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  debounce_state_e  state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dout_n;
  logic             fire;
  logic             rise_n, fall_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = dout;
    fire    = 1'b0;
    case (state)
      DB_STABLE: begin
        cnt_n = '0;
        if (din != dout) begin
          // A single-sample window accepts the new level immediately.
          if (DEBOUNCE_CYCLES == 1) begin
            dout_n = din;
            fire   = 1'b1;
          end else begin
            cnt_n   = CNT_ONE;
            state_n = DB_PEND;
          end
        end
      end
      DB_PEND: begin
        if (din == dout) begin
          cnt_n   = '0;
          state_n = DB_STABLE;
        end else if (cnt == CNT_LAST) begin
          dout_n  = din;
          cnt_n   = '0;
          state_n = DB_STABLE;
          fire    = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = DB_STABLE;
      end
    endcase
    // On an accepted change din is the new level, so it selects the edge type.
    rise_n = fire & din;
    fall_n = fire & ~din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DB_STABLE;
      cnt       <= '0;
      dout      <= RESET_VALUE;
      rise      <= 1'b0;
      fall      <= 1'b0;
      rise_pend <= 1'b0;
      fall_pend <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dout      <= dout_n;
      rise      <= rise_n;
      fall      <= fall_n;
      // A new event outranks a simultaneous clear so no edge is lost.
      rise_pend <= rise_n | (rise_pend & ~clr_rise);
      fall_pend <= fall_n | (fall_pend & ~clr_fall);
    end
  end

  assign busy = (state == DB_PEND);

endmodule
`default_nettype wire

// File: tb/tb_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_debounce : directed checks of debounce for N=4, N=1 and RESET_VALUE=1
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // a: N=4 RV=0, b: N=1 RV=0, c: N=4 RV=1
  logic rst_a = 1'b1, din_a = 1'b0, clr_rise_a = 1'b0, clr_fall_a = 1'b0;
  logic rst_b = 1'b1, din_b = 1'b0, clr_rise_b = 1'b0, clr_fall_b = 1'b0;
  logic rst_c = 1'b1, din_c = 1'b1, clr_rise_c = 1'b0, clr_fall_c = 1'b0;
  logic dout_a, rise_a, fall_a, rise_pend_a, fall_pend_a, busy_a;
  logic dout_b, rise_b, fall_b, rise_pend_b, fall_pend_b, busy_b;
  logic dout_c, rise_c, fall_c, rise_pend_c, fall_pend_c, busy_c;

  debounce #(.DEBOUNCE_CYCLES(4), .RESET_VALUE(1'b0)) dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .clr_rise(clr_rise_a), .clr_fall(clr_fall_a),
    .dout(dout_a), .rise(rise_a), .fall(fall_a), .rise_pend(rise_pend_a),
    .fall_pend(fall_pend_a), .busy(busy_a));

  debounce #(.DEBOUNCE_CYCLES(1), .RESET_VALUE(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .clr_rise(clr_rise_b), .clr_fall(clr_fall_b),
    .dout(dout_b), .rise(rise_b), .fall(fall_b), .rise_pend(rise_pend_b),
    .fall_pend(fall_pend_b), .busy(busy_b));

  debounce #(.DEBOUNCE_CYCLES(4), .RESET_VALUE(1'b1)) dut_c (
    .clk(clk), .rst(rst_c), .din(din_c), .clr_rise(clr_rise_c), .clr_fall(clr_fall_c),
    .dout(dout_c), .rise(rise_c), .fall(fall_c), .rise_pend(rise_pend_c),
    .fall_pend(fall_pend_c), .busy(busy_c));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic pat_din  [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  logic pat_busy [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  int   pat_cnt  [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    // Test 1: reset state, then a clean rise on N=4
    tick(); tick();
    check("a_rst_dout", dout_a, 0);
    check("a_rst_busy", busy_a, 0);
    check("a_rst_rise", rise_a, 0);
    check("a_rst_rpend", rise_pend_a, 0);
    check("a_rst_fpend", fall_pend_a, 0);
    check("a_rst_cnt", dut_a.cnt, 0);
    check("c_rst_dout", dout_c, 1);
    check("c_rst_pulse", {rise_c, fall_c}, 0);
    check("c_rst_busy", busy_c, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    din_a = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("t1_e%0d_dout", e), dout_a, 0);
      check($sformatf("t1_e%0d_busy", e), busy_a, 1);
      check($sformatf("t1_e%0d_cnt", e), dut_a.cnt, e);
    end
    tick();
    check("t1_e4_dout", dout_a, 1);
    check("t1_e4_rise", rise_a, 1);
    check("t1_e4_fall", fall_a, 0);
    check("t1_e4_busy", busy_a, 0);
    check("t1_e4_rpend", rise_pend_a, 1);
    tick();
    check("t1_e5_rise", rise_a, 0);
    check("t1_e5_rpend", rise_pend_a, 1);
    check("t1_e5_dout", dout_a, 1);
    check("c_idle_dout", dout_c, 1);

    // Test 3: fall with clear coinciding with the set edge
    din_a = 1'b0;
    tick(); tick(); tick();
    check("t3_e3_dout", dout_a, 1);
    check("t3_e3_fall", fall_a, 0);
    clr_fall_a = 1'b1;
    tick();
    check("t3_e4_dout", dout_a, 0);
    check("t3_e4_fall", fall_a, 1);
    check("t3_e4_fpend", fall_pend_a, 1);
    tick();
    check("t3_e5_fall", fall_a, 0);
    check("t3_e5_fpend", fall_pend_a, 0);
    check("t3_e5_rpend", rise_pend_a, 1);
    clr_fall_a = 1'b0;
    clr_rise_a = 1'b1;
    tick();
    check("t3_clr_rpend", rise_pend_a, 0);
    tick();
    check("t3_clr_idle", rise_pend_a, 0);
    clr_rise_a = 1'b0;

    // Test 2: glitch pattern never qualifies
    for (int i = 0; i < 8; i++) begin
      din_a = pat_din[i];
      tick();
      check($sformatf("t2_%0d_dout", i), dout_a, 0);
      check($sformatf("t2_%0d_rise", i), rise_a, 0);
      check($sformatf("t2_%0d_busy", i), busy_a, pat_busy[i]);
      check($sformatf("t2_%0d_cnt", i), dut_a.cnt, pat_cnt[i]);
    end
    check("t2_rpend", rise_pend_a, 0);

    // Test 4: reset mid-qualification
    din_a = 1'b1;
    tick(); tick();
    check("t4_pre_cnt", dut_a.cnt, 2);
    rst_a = 1'b1;
    tick();
    check("t4_rst_dout", dout_a, 0);
    check("t4_rst_busy", busy_a, 0);
    check("t4_rst_cnt", dut_a.cnt, 0);
    check("t4_rst_rise", rise_a, 0);
    rst_a = 1'b0;
    tick(); tick(); tick();
    check("t4_e3_dout", dout_a, 0);
    check("t4_e3_rise", rise_a, 0);
    tick();
    check("t4_e4_dout", dout_a, 1);
    check("t4_e4_rise", rise_a, 1);
    check("t4_e4_rpend", rise_pend_a, 1);

    // Test 5: N=1 follows one cycle late
    check("t5_init_dout", dout_b, 0);
    din_b = 1'b1;
    tick();
    check("t5_1_dout", dout_b, 1);
    check("t5_1_rise", rise_b, 1);
    check("t5_1_fall", fall_b, 0);
    check("t5_1_busy", busy_b, 0);
    din_b = 1'b0;
    tick();
    check("t5_2_dout", dout_b, 0);
    check("t5_2_rise", rise_b, 0);
    check("t5_2_fall", fall_b, 1);
    tick();
    check("t5_3_pulses", {rise_b, fall_b}, 0);
    check("t5_pends", {rise_pend_b, fall_pend_b}, 2'b11);

    // Test 6: RESET_VALUE=1, fall qualification
    din_c = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("t6_e%0d_dout", e), dout_c, 1);
      check($sformatf("t6_e%0d_fall", e), fall_c, 0);
    end
    tick();
    check("t6_e4_dout", dout_c, 0);
    check("t6_e4_fall", fall_c, 1);
    check("t6_e4_rise", rise_c, 0);
    check("t6_e4_fpend", fall_pend_c, 1);
    check("t6_e4_rpend", rise_pend_c, 0);
    tick();
    check("t6_e5_fall", fall_c, 0);
    check("t6_e5_rpend", rise_pend_c, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
